// File: rtl/stim_sequencer.sv
// Burst/envelope controller: it sequences the ON/OFF windows and issues a pulse trigger and a DAC code on each period tick.
// Optional feature: define STIM_RAMP_DOWN_EN to add a RAMP_DOWN phase at the end of each ON window.
module stim_sequencer #(
    parameter int AMP_W = 6,
    parameter int PER_W = 12
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [AMP_W-1:0] amplitude,
    input  logic [PER_W-1:0] freq,
    input  logic [5:0]       ramp,
    input  logic [9:0]       ramp_factor,
    input  logic [7:0]       on_time,
    input  logic [9:0]       off_time,
    input  logic             pulse_busy,
    output logic             pulse_trigger,
    output logic [AMP_W-1:0] dac_amp,
    output logic             burst_on,
    output logic             overrun
);
    localparam int ACC_W = AMP_W + 4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RAMP_UP   = 3'd1;
    localparam logic [2:0] S_PLATEAU   = 3'd2;
    localparam logic [2:0] S_OFF       = 3'd4;
`ifdef STIM_RAMP_DOWN_EN
    localparam logic [2:0] S_RAMP_DOWN = 3'd3;
`endif

    logic [2:0]       state, state_n;
    logic [PER_W-1:0] pcnt_t, pcnt_n;
    logic [7:0]       pidx, pidx_n, pidx_inc, on_eff;
    logic [9:0]       ocnt, ocnt_n;
    logic [ACC_W-1:0] acc, acc_n, acc_t, acc_cap, acc_up_sat;
    logic [ACC_W:0]   acc_up;
    logic             tick, fire, win_start, win_end, burst_n;

    // Window configuration, frozen for the duration of a window
    logic [AMP_W-1:0] amp_s;
    logic [PER_W-1:0] freq_s;
    logic [5:0]       ramp_s;
    logic [9:0]       rf_s;
    logic [7:0]       on_s;
    logic [9:0]       off_s;

    assign tick     = (pcnt_t == freq_s - PER_W'(1));
    assign pidx_inc = pidx + 8'd1;
    assign on_eff   = (on_s == 8'd0) ? 8'd1 : on_s;
    assign acc_cap  = {amp_s, 4'b0000};

    // All accumulator arithmetic carries one extra bit so overflow/underflow is visible
    assign acc_up     = {1'b0, acc} + (ACC_W+1)'(rf_s);
    assign acc_up_sat = (acc_up > {1'b0, acc_cap}) ? acc_cap : acc_up[ACC_W-1:0];

`ifdef STIM_RAMP_DOWN_EN
    logic [ACC_W:0]   acc_dn;
    logic [ACC_W-1:0] acc_dn_sat;
    logic             near_end;
    assign acc_dn     = {1'b0, acc} - (ACC_W+1)'(rf_s);
    assign acc_dn_sat = acc_dn[ACC_W] ? '0 : acc_dn[ACC_W-1:0];
    assign near_end   = ({1'b0, on_eff} - {1'b0, pidx_inc}) <= {3'b000, ramp_s};
`endif

    // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_n   = state;
        pcnt_n    = pcnt_t;
        pidx_n    = pidx;
        ocnt_n    = ocnt;
        acc_t     = acc;
        acc_n     = acc;
        fire      = 1'b0;
        win_start = 1'b0;
        win_end   = 1'b0;

        if (state != S_IDLE) pcnt_n = tick ? '0 : pcnt_t + PER_W'(1);

        case (state)
            S_IDLE: begin
                if (freq >= PER_W'(2)) begin
                    state_n   = S_RAMP_UP;
                    acc_n     = '0;
                    win_start = 1'b1;
                end
            end
            S_OFF: begin
                if (tick) begin
                    ocnt_n = ocnt + 10'd1;
                    if (ocnt_n >= off_s) win_end = 1'b1;
                end
            end
`ifdef STIM_RAMP_DOWN_EN
            S_RAMP_UP, S_PLATEAU, S_RAMP_DOWN: begin
`else
            S_RAMP_UP, S_PLATEAU: begin
`endif
                if (tick) begin
                    fire   = 1'b1;
                    pidx_n = pidx_inc;
                    if (state == S_RAMP_UP) begin
                        acc_t = acc_up_sat;
                        if ({2'b00, ramp_s} <= pidx_inc) begin
                            acc_t   = acc_cap;
                            state_n = S_PLATEAU;
`ifdef STIM_RAMP_DOWN_EN
                            if (near_end) state_n = S_RAMP_DOWN;
`endif
                        end
                    end
`ifdef STIM_RAMP_DOWN_EN
                    else if (state == S_PLATEAU) begin
                        if (near_end) state_n = S_RAMP_DOWN;
                    end else begin
                        acc_t = acc_dn_sat;
                    end
`endif
                    acc_n = acc_t;
                    if (pidx_inc >= on_eff) begin
                        if (freq >= PER_W'(2) && off_s != 10'd0) begin
                            state_n = S_OFF;
                            ocnt_n  = '0;
                            acc_n   = '0;
                        end else begin
                            win_end = 1'b1;
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Window boundary: restart the envelope, or park if the period became unusable
        if (win_end) begin
            acc_n  = '0;
            pidx_n = '0;
            pcnt_n = '0;
            if (freq < PER_W'(2)) begin
                state_n = S_IDLE;
            end else begin
                state_n   = S_RAMP_UP;
                win_start = 1'b1;
            end
        end

        if (!enable) begin
            state_n   = S_IDLE;
            pcnt_n    = '0;
            pidx_n    = '0;
            ocnt_n    = '0;
            acc_n     = '0;
            fire      = 1'b0;
            win_start = 1'b0;
        end

`ifdef STIM_RAMP_DOWN_EN
        burst_n = (state_n == S_RAMP_UP) || (state_n == S_PLATEAU) || (state_n == S_RAMP_DOWN);
`else
        burst_n = (state_n == S_RAMP_UP) || (state_n == S_PLATEAU);
`endif
    end

    // NOTE: shadow registers are reset too, although they are reloaded before use, so no X can reach tick or acc.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            pcnt_t        <= '0;
            pidx          <= '0;
            ocnt          <= '0;
            acc           <= '0;
            amp_s         <= '0;
            freq_s        <= '0;
            ramp_s        <= '0;
            rf_s          <= '0;
            on_s          <= '0;
            off_s         <= '0;
            pulse_trigger <= 1'b0;
            dac_amp       <= '0;
            burst_on      <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state    <= state_n;
            pcnt_t   <= pcnt_n;
            pidx     <= pidx_n;
            ocnt     <= ocnt_n;
            acc      <= acc_n;
            burst_on <= burst_n;
            if (win_start) begin
                amp_s  <= amplitude;
                freq_s <= freq;
                ramp_s <= ramp;
                rf_s   <= ramp_factor;
                on_s   <= on_time;
                off_s  <= off_time;
            end
            pulse_trigger <= fire & ~pulse_busy;
            if (fire && !pulse_busy)
                dac_amp <= acc_t[ACC_W-1:4];
            else if (state_n == S_IDLE || state_n == S_OFF)
                dac_amp <= '0;
            if (state_n == S_IDLE)
                overrun <= 1'b0;
            else if (fire && pulse_busy)
                overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_stim_sequencer.sv
// Directed self-checking bench for stim_sequencer: trigger timing, DAC codes, overrun, enable and reset behaviour.
// Honours STIM_RAMP_DOWN_EN in the same way as the design when it builds the expected ON-window codes.
module tb_stim_sequencer;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic [5:0]  amplitude = '0;
    logic [11:0] freq = '0;
    logic [5:0]  ramp = '0;
    logic [9:0]  ramp_factor = '0;
    logic [7:0]  on_time = '0;
    logic [9:0]  off_time = '0;
    logic        pulse_busy = 1'b0;
    logic        pulse_trigger;
    logic [5:0]  dac_amp;
    logic        burst_on;
    logic        overrun;

    stim_sequencer #(.AMP_W(6), .PER_W(12)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .amplitude(amplitude), .freq(freq),
        .ramp(ramp), .ramp_factor(ramp_factor), .on_time(on_time), .off_time(off_time),
        .pulse_busy(pulse_busy), .pulse_trigger(pulse_trigger), .dac_amp(dac_amp),
        .burst_on(burst_on), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int dac; } trig_t;
    trig_t trig_q[$];

    // Triggers are captured 1 ns after the edge that raises them
    always @(posedge clk) begin
        trig_t t;
        #1;
        if (pulse_trigger) begin
            t.cyc = cyc;
            t.dac = int'(dac_amp);
            trig_q.push_back(t);
        end
    end

    typedef struct { int dac; int gap; } vec_t;
    vec_t vecs[20];
    int   ref_codes[10];
    int   errors = 0;
    int   checks = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg(int a, int r, int rf, int f, int on, int off);
        amplitude   = 6'(a);
        ramp        = 6'(r);
        ramp_factor = 10'(rf);
        freq        = 12'(f);
        on_time     = 8'(on);
        off_time    = 10'(off);
    endtask

    // Raises enable; k is the index of the edge that samples it
    task automatic start(output int k);
        @(negedge clk);
        trig_q.delete();
        enable = 1'b1;
        k = cyc + 1;
    endtask

    task automatic stop();
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_trig(string name, int n, int budget);
        int b = 0;
        while (trig_q.size() < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (trig_q.size() < n) check($sformatf("%s timeout", name), trig_q.size(), n);
    endtask

    task automatic check_trig(string tag, int i, int k, int exp_dac, int exp_gap);
        int base;
        check($sformatf("%s[%0d] present", tag, i), int'(trig_q.size() > i), 1);
        if (trig_q.size() <= i) return;
        base = (i == 0) ? k : trig_q[i-1].cyc;
        check($sformatf("%s[%0d] dac", tag, i), trig_q[i].dac, exp_dac);
        check($sformatf("%s[%0d] gap", tag, i), trig_q[i].cyc - base, exp_gap);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
`ifdef STIM_RAMP_DOWN_EN
        ref_codes = '{5, 10, 15, 20, 25, 20, 15, 10, 5, 0};
`else
        ref_codes = '{5, 10, 15, 20, 25, 25, 25, 25, 25, 25};
`endif
        // Two consecutive windows: 4-cycle spacing, 24 cycles across the 20-cycle OFF window
        for (int i = 0; i < 20; i++) begin
            vecs[i].dac = ref_codes[i % 10];
            vecs[i].gap = (i == 10) ? 24 : 4;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst trigger", int'(pulse_trigger), 0);
        check("rst dac", int'(dac_amp), 0);
        check("rst burst", int'(burst_on), 0);
        check("rst overrun", int'(overrun), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Two full windows
        cfg(25, 5, 80, 4, 10, 5);
        start(k);
        wait_trig("win", 1, 50);
        check("burst mid", int'(burst_on), 1);
        wait_trig("win", 10, 100);
        @(negedge clk);
        check("burst after last", int'(burst_on), 0);
        check("off dac", int'(dac_amp), 0);
        wait_trig("win", 20, 200);
        for (int i = 0; i < 20; i++) check_trig("win", i, k, vecs[i].dac, vecs[i].gap);
        stop();

        // Direct plateau, off_time=0: triggers back to back
        cfg(30, 0, 0, 400, 2, 0);
        start(k);
        wait_trig("flat", 4, 2000);
        for (int i = 0; i < 4; i++) check_trig("flat", i, k, 30, 400);
        stop();

        // on_time=0 acts as 1
        cfg(10, 0, 16, 2, 0, 1);
        start(k);
        wait_trig("on0", 3, 100);
        check_trig("on0", 0, k, 10, 2);
        check_trig("on0", 1, k, 10, 4);
        check_trig("on0", 2, k, 10, 4);
        stop();

        // freq=1 never starts
        cfg(10, 0, 16, 1, 2, 1);
        start(k);
        repeat (10) @(negedge clk);
        check("freq1 burst", int'(burst_on), 0);
        check("freq1 triggers", trig_q.size(), 0);
        stop();

        // pulse_busy over the third tick: dropped trigger, sticky overrun
        cfg(25, 5, 80, 4, 10, 5);
        start(k);
        wait_trig("busy", 2, 50);
        pulse_busy = 1'b1;
        repeat (4) @(negedge clk);
        pulse_busy = 1'b0;
        check("busy overrun set", int'(overrun), 1);
        repeat (40) @(negedge clk);
        check("busy count", trig_q.size(), 9);
        check("busy overrun sticky", int'(overrun), 1);
        check_trig("busy", 0, k, 5, 4);
        check_trig("busy", 1, k, 10, 4);
        check_trig("busy", 2, k, ref_codes[3], 8);
        for (int i = 3; i < 9; i++) check_trig("busy", i, k, ref_codes[i+1], 4);
        stop();
        check("busy overrun cleared", int'(overrun), 0);

        // enable dropped two cycles after the second trigger, then re-enabled
        pulse_busy = 1'b1;
        start(k);
        repeat (5) @(negedge clk);
        pulse_busy = 1'b0;
        check("drop overrun set", int'(overrun), 1);
        wait_trig("drop", 2, 50);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        check("drop count", trig_q.size(), 2);
        check_trig("drop", 0, k, 10, 8);
        check_trig("drop", 1, k, 15, 4);
        check("drop dac", int'(dac_amp), 0);
        check("drop overrun", int'(overrun), 0);
        check("drop burst", int'(burst_on), 0);
        start(k);
        wait_trig("reen", 1, 50);
        check_trig("reen", 0, k, 5, 4);
        stop();

        // Asynchronous reset during the plateau
        start(k);
        wait_trig("rstmid", 7, 100);
        check("rstmid pre trigger", int'(pulse_trigger), 1);
        check("rstmid pre dac", int'(dac_amp), ref_codes[6]);
        resetn = 1'b0;
        enable = 1'b0;
        #1;
        check("rstmid trigger", int'(pulse_trigger), 0);
        check("rstmid dac", int'(dac_amp), 0);
        check("rstmid burst", int'(burst_on), 0);
        check("rstmid overrun", int'(overrun), 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        check("rstmid idle burst", int'(burst_on), 0);
        check("rstmid idle count", trig_q.size(), 7);
        start(k);
        wait_trig("rstmid restart", 1, 50);
        check_trig("rstmid restart", 0, k, 5, 4);
        stop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
